fpu_32_add_operand_stage: RTL
=============================

Name: fpu_32_add_operand_stage

Overview:
- Registered issue stage directly upstream of the combinational fpu_32_adder.
- Accepts operand pairs over a valid/ready handshake and applies the subtract sign flip.
- Classifies both operands and resolves IEEE-754 special cases (NaN, Inf, zero) into a bypass result.
- Orders operands so the larger magnitude is presented on out_a, giving the adder a fixed, registered, back-pressurable input.

Parameters:
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept; registered.
- in_a  input  32  IEEE-754 single operand A.
- in_b  input  32  IEEE-754 single operand B.
- in_sub  input  1  1: compute A-B (flip sign of B before processing).
- out_valid  output  1  ordered operands / bypass valid.
- out_ready  input  1  downstream accepts.
- out_a  output  32  larger-magnitude operand.
- out_b  output  32  smaller-magnitude operand (sign already adjusted for in_sub).
- out_swapped  output  1  1: out_a came from B.
- out_bypass  output  1  1: out_bypass_result is final; adder result must be ignored.
- out_bypass_result  output  32  special-case result.
- out_invalid  output  1  invalid operation (NaN input or Inf-Inf).
- acc_count  output  CNT_W  number of accepted input transactions, wraps.

Behaviour:
- Reset (async assert, sync deassert handled by system):
  - in_ready=1, out_valid=0, all out_* data/flags=0, acc_count=0, skid buffer empty.
- Transfer rules: input accepted when in_valid&in_ready; output consumed when out_valid&out_ready.
- Latency: 1 cycle from acceptance to out_valid when the output register is empty or being drained that cycle.
- Buffering: output register plus one skid entry.
  - in_ready = skid entry empty (registered; no combinational path from out_ready).
  - Output stalled and input accepted: the entry goes to the skid slot; in_ready drops next cycle.
  - Output drains: skid moves to the output register, in_ready returns to 1 next cycle.
  - Order is strictly FIFO; no drops or duplicates.
  - out_* values hold stable while out_valid=1 and out_ready=0.
- Sign adjust: b' = {in_b[31]^in_sub, in_b[30:0]}.
- Classes per operand: NaN (exp=FF, man!=0), Inf (exp=FF, man=0), zero (exp=0, man=0), denormal (exp=0, man!=0), normal.
- Special-case priority (first match wins):
  1. Either operand NaN: bypass=1, result 32'h7FC00000, invalid=1.
  2. Both Inf with differing signs: bypass=1, result 32'h7FC00000, invalid=1.
  3. Exactly one Inf, or both Inf with the same sign: bypass=1, result = that Inf.
  4. Both zero: bypass=1, result = {a.sign & b'.sign, 31'b0}.
  5. Otherwise: bypass=0, result=0, invalid=0.
- Ordering:
  - Compare {exp,man} (31-bit unsigned).
  - b' strictly greater: out_a=b', out_b=a, swapped=1.
  - Otherwise (including equal): out_a=a, out_b=b', swapped=0.
  - Ordering applies in bypass cases too.
- acc_count increments by 1 on every accepted input; wraps from all-ones to 0.
- Simultaneous accept and drain with the skid empty: new entry loads the output register directly; out_valid stays 1.
- Reset asserted mid-stream: all in-flight entries are discarded immediately.

Optional Feature:
- Macro: FPU_FTZ_EN.
- Defined: denormal operands are flushed to signed zero before classification and ordering (sign kept, exp/man cleared). Both flushed to zero then takes the zero bypass.
- Undefined: denormals pass through unchanged, classified as non-special, no bypass.

Test Plan:
- a=0x4348947B (200.58), b=0x422E6666 (43.6), sub=0 -> out_valid exactly 1 cycle after accept; out_a=0x4348947B, out_b=0x422E6666, swapped=0, bypass=0.
- a=0xC191F7CF (-18.246), b=0x41FB6C8B (31.428) -> out_a=0x41FB6C8B, out_b=0xC191F7CF, swapped=1; then a=0x42FE0000, b=0x42FC0000, sub=1 -> out_a=0x42FE0000, out_b=0xC2FC0000.
- a=b=0xFF800000 -> bypass=1, result=0xFF800000, invalid=0; a=0x7F800000, b=0xFF800000 -> result=0x7FC00000, invalid=1; a=0x7FC00001, b=0x40200000 -> result=0x7FC00000, invalid=1.
- a=0x80000000, b=0x80000000 -> result=0x80000000; a=0x80000000, b=0x00000000 -> result=0x00000000; a=0x00000001, b=0x00000000 -> bypass=1 with FPU_FTZ_EN defined, bypass=0 without.
- out_ready=0 for 4 cycles while 3 pairs are offered back-to-back -> in_ready drops after 2 accepts, third pair held; release -> 3 outputs in order, no loss; acc_count=3.
- Assert rst_n low with 2 entries buffered -> out_valid=0, in_ready=1, acc_count=0 immediately; first post-reset pair emerges 1 cycle after accept.

Source files
------------

// File: rtl/fpu_32_add_operand_stage.sv
// ---------------------------------------------------------------------------
// fpu_32_add_operand_stage
//
// Registered issue stage that sits directly in front of the combinational
// fpu_32_adder. Each accepted operand pair gets:
//   * the subtract sign flip applied to B (b' = B with sign ^ in_sub),
//   * IEEE-754 special-case resolution (NaN, Inf, zero) into a bypass result,
//   * magnitude ordering so the larger {exp,man} is presented on out_a.
// The results are held in an output register backed by one skid entry.
// The adder therefore sees a fixed, registered, back-pressurable input.
//
// Configuration macro:
//   FPU_FTZ_EN  when defined, denormal operands are flushed to signed zero
//               before classification and ordering. When undefined,
//               denormals pass through and are treated as ordinary
//               non-special values.
//
// Parameters:
//   CNT_W              width of the accepted-transaction counter (wraps)
//
// Ports:
//   clk                single clock, rising edge
//   rst_n              asynchronous active-low reset
//   in_valid/in_ready  input handshake (in_ready is registered)
//   in_a, in_b         IEEE-754 single-precision operands
//   in_sub             1: compute A-B (sign of B flipped before processing)
//   out_valid/out_ready output handshake
//   out_a              larger-magnitude operand
//   out_b              smaller-magnitude operand (sign adjusted for in_sub)
//   out_swapped        1: out_a came from B
//   out_bypass         1: out_bypass_result is final, ignore adder result
//   out_bypass_result  special-case result
//   out_invalid        invalid operation (NaN input or Inf-Inf)
//   acc_count          number of accepted input transactions
//
// Control state: the stage has no encoded FSM. Its whole control state is
// the pair of occupancy flags (output register valid, skid entry valid),
// visible as out_valid and ~in_ready.
// ---------------------------------------------------------------------------
module fpu_32_add_operand_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_swapped,
    output logic             out_bypass,
    output logic [31:0]      out_bypass_result,
    output logic             out_invalid,
    output logic [CNT_W-1:0] acc_count
);

    // Handshake semantics (both sides): a transfer happens on a rising edge
    // where valid and ready are both 1. A producer holding valid=1 keeps its
    // data stable until the transfer. in_ready depends only on registered
    // state (skid slot empty), so there is no combinational path from
    // out_ready to in_ready. While out_valid=1 and out_ready=0 every out_*
    // signal holds its value.

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // One fully processed operand pair, as stored in the output register
    // and in the skid slot.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        swapped;
        logic        bypass;
        logic [31:0] result;
        logic        invalid;
    } entry_t;

    // -----------------------------------------------------------------------
    // Operand conditioning: sign flip for subtract, optional flush-to-zero
    // -----------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        op_a = in_a;
        op_b = {in_b[31] ^ in_sub, in_b[30:0]};
`ifdef FPU_FTZ_EN
        // A zero exponent means zero or denormal. Clearing the mantissa
        // turns a denormal into a signed zero and leaves a zero unchanged.
        if (op_a[30:23] == 8'h00) begin
            op_a = {op_a[31], 31'b0};
        end
        if (op_b[30:23] == 8'h00) begin
            op_b = {op_b[31], 31'b0};
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Classification
    // -----------------------------------------------------------------------
    logic a_exp_max;
    logic b_exp_max;
    logic a_exp_zero;
    logic b_exp_zero;
    logic a_man_nz;
    logic b_man_nz;
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
    logic a_zero;
    logic b_zero;

    always_comb begin
        a_exp_max  = &op_a[30:23];
        b_exp_max  = &op_b[30:23];
        a_exp_zero = ~|op_a[30:23];
        b_exp_zero = ~|op_b[30:23];
        a_man_nz   = |op_a[22:0];
        b_man_nz   = |op_b[22:0];

        a_nan  = a_exp_max & a_man_nz;
        b_nan  = b_exp_max & b_man_nz;
        a_inf  = a_exp_max & ~a_man_nz;
        b_inf  = b_exp_max & ~b_man_nz;
        a_zero = a_exp_zero & ~a_man_nz;
        b_zero = b_exp_zero & ~b_man_nz;
    end

    // -----------------------------------------------------------------------
    // Ordering and special-case resolution -> new entry
    // -----------------------------------------------------------------------
    logic   swap;
    entry_t new_entry;

    always_comb begin
        new_entry = '0;

        // {exp,man} compared as an unsigned 31-bit value matches IEEE
        // magnitude ordering. On a tie A stays on top so out_swapped is 0.
        swap = (op_b[30:0] > op_a[30:0]);

        new_entry.swapped = swap;
        new_entry.a       = swap ? op_b : op_a;
        new_entry.b       = swap ? op_a : op_b;

        // Priority chain: NaN beats Inf-Inf, which beats a single Inf,
        // which beats zero+zero.
        if (a_nan || b_nan) begin
            new_entry.bypass  = 1'b1;
            new_entry.result  = QNAN;
            new_entry.invalid = 1'b1;
        end else if (a_inf && b_inf && (op_a[31] != op_b[31])) begin
            new_entry.bypass  = 1'b1;
            new_entry.result  = QNAN;
            new_entry.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            // Both Inf here means same sign, so either operand is correct.
            new_entry.bypass = 1'b1;
            new_entry.result = a_inf ? op_a : op_b;
        end else if (a_zero && b_zero) begin
            // Sum of zeros is -0 only when both are -0 (round-to-nearest).
            new_entry.bypass = 1'b1;
            new_entry.result = {op_a[31] & op_b[31], 31'b0};
        end
    end

    // -----------------------------------------------------------------------
    // Output register + one skid entry
    // -----------------------------------------------------------------------
    entry_t            out_q;
    logic              out_valid_q;
    entry_t            skid_q;
    logic              skid_valid_q;
    logic [CNT_W-1:0]  cnt_q;

    logic accept;
    logic out_free;

    always_comb begin
        accept   = in_valid & ~skid_valid_q;
        // The output register can take a new entry when it is empty or
        // is being consumed on this edge.
        out_free = ~out_valid_q | out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (out_free) begin
                if (skid_valid_q) begin
                    // The skid entry is older than anything on the input.
                    // While the skid slot is full, accept is 0, so nothing
                    // new arrives this cycle.
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= new_entry;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                // Output is stalled. Park the new entry in the skid slot.
                // in_ready drops on the next cycle.
                skid_q       <= new_entry;
                skid_valid_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready          = ~skid_valid_q;
    assign out_valid         = out_valid_q;
    assign out_a             = out_q.a;
    assign out_b             = out_q.b;
    assign out_swapped       = out_q.swapped;
    assign out_bypass        = out_q.bypass;
    assign out_bypass_result = out_q.result;
    assign out_invalid       = out_q.invalid;
    assign acc_count         = cnt_q;

endmodule
